// File: rtl/invader_grid.sv
// Invader formation: alive bitmap, marching position, and one-cell-per-cycle laser hit scan.
// States: IDLE wait frame | SAMPLE latch laser | SCAN test one cell per cycle | MOVE step timer and march
module invader_grid #(
    parameter int COLS            = 6,
    parameter int ROWS            = 4,
    parameter int INV_W           = 32,
    parameter int INV_H           = 32,
    parameter int GAP_X           = 16,
    parameter int GAP_Y           = 16,
    parameter int START_X         = 64,
    parameter int START_Y         = 48,
    parameter int STEP_X          = 4,
    parameter int STEP_Y          = 16,
    parameter int RIGHT_BOUND     = 640,
    parameter int FLOOR_Y         = 400,
    parameter int FRAMES_PER_STEP = 8,
    parameter int PROJ_W          = 4,
    parameter int PROJ_H          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame,
    input  logic                 laser_active,
    input  logic [9:0]           laser_x,
    input  logic [9:0]           laser_y,
    output logic [COLS-1:0]      invader_collision,
    output logic                 score_pulse,
    output logic [COLS*ROWS-1:0] alive,
    output logic [9:0]           grid_x,
    output logic [9:0]           grid_y,
    output logic                 done
);

    localparam int NCELL = COLS * ROWS;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int FW    = $clog2(FRAMES_PER_STEP + 1);

    localparam logic [10:0] PITCH_X = 11'(INV_W + GAP_X);
    localparam logic [10:0] PITCH_Y = 11'(INV_H + GAP_Y);
    localparam logic [10:0] INV_W11 = 11'(INV_W);
    localparam logic [10:0] INV_H11 = 11'(INV_H);
    localparam logic [10:0] PW11    = 11'(PROJ_W);
    localparam logic [10:0] PH11    = 11'(PROJ_H);
    localparam logic [10:0] SX11    = 11'(STEP_X);
    localparam logic [10:0] RB11    = 11'(RIGHT_BOUND);
    localparam logic [10:0] FL11    = 11'(FLOOR_Y);

    typedef enum logic [1:0] {IDLE, SAMPLE, SCAN, MOVE} state_t;

    state_t        state;
    logic [CW-1:0] scan_col;
    logic [RW-1:0] scan_row;
    logic [9:0]    lat_x;
    logic [9:0]    lat_y;
    logic          dir_right;
    logic [FW-1:0] frame_cnt;

    logic [10:0]   cell_x, cell_y, lx11, ly11;
    logic [IW-1:0] cell_idx;
    logic          cell_hit, last_cell;

    logic [COLS-1:0] col_alive;
    logic [ROWS-1:0] row_alive;
    logic [CW-1:0]   left_col, right_col;
    logic [RW-1:0]   low_row;
    logic [10:0]     right_edge, left_x, bottom_edge;
    logic            hit_right, hit_left, floor_hit;

    always_comb begin
        lx11      = {1'b0, lat_x};
        ly11      = {1'b0, lat_y};
        cell_x    = {1'b0, grid_x} + 11'(scan_col) * PITCH_X;
        cell_y    = {1'b0, grid_y} + 11'(scan_row) * PITCH_Y;
        cell_idx  = IW'(scan_row) * IW'(COLS) + IW'(scan_col);
        cell_hit  = alive[cell_idx]
                    && (lx11 < cell_x + INV_W11) && (lx11 + PW11 > cell_x)
                    && (ly11 < cell_y + INV_H11) && (ly11 + PH11 > cell_y);
        last_cell = (scan_row == '0) && (scan_col == CW'(COLS - 1));
    end

    // Formation extents follow only the surviving invaders.
    always_comb begin
        col_alive = '0;
        row_alive = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive[r*COLS + c]) begin
                    col_alive[c] = 1'b1;
                    row_alive[r] = 1'b1;
                end
            end
        end
        left_col  = '0;
        right_col = '0;
        low_row   = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_alive[c]) left_col = CW'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_alive[c]) right_col = CW'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_alive[r]) low_row = RW'(r);
        end
        right_edge  = {1'b0, grid_x} + 11'(right_col) * PITCH_X + INV_W11;
        left_x      = {1'b0, grid_x} + 11'(left_col) * PITCH_X;
        bottom_edge = {1'b0, grid_y} + 11'(low_row) * PITCH_Y + INV_H11;
        hit_right   = (right_edge + SX11) > RB11;
        hit_left    = left_x < SX11;
        floor_hit   = (|alive) && (bottom_edge >= FL11);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            scan_col          <= '0;
            scan_row          <= '0;
            lat_x             <= '0;
            lat_y             <= '0;
            dir_right         <= 1'b1;
            frame_cnt         <= '0;
            alive             <= '1;
            grid_x            <= 10'(START_X);
            grid_y            <= 10'(START_Y);
            invader_collision <= '0;
            score_pulse       <= 1'b0;
            done              <= 1'b0;
        end else begin
            invader_collision <= '0;
            score_pulse       <= 1'b0;
            if (alive == '0 || floor_hit) begin
                done <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame && !done) state <= SAMPLE;
                end
                SAMPLE: begin
                    lat_x    <= laser_x;
                    lat_y    <= laser_y;
                    scan_row <= RW'(ROWS - 1);
                    scan_col <= '0;
                    state    <= laser_active ? SCAN : MOVE;
                end
                SCAN: begin
                    if (cell_hit) begin
                        alive[cell_idx]   <= 1'b0;
                        invader_collision <= COLS'(1) << scan_col;
                        score_pulse       <= 1'b1;
                        state             <= MOVE;
                    end else if (last_cell) begin
                        state <= MOVE;
                    end else if (scan_col == CW'(COLS - 1)) begin
                        scan_col <= '0;
                        scan_row <= scan_row - RW'(1);
                    end else begin
                        scan_col <= scan_col + CW'(1);
                    end
                end
                MOVE: begin
                    state <= IDLE;
                    // An emptied formation has no extent; hold position until done freezes it.
                    if (alive != '0) begin
                        if (frame_cnt == FW'(FRAMES_PER_STEP - 1)) begin
                            frame_cnt <= '0;
                            if (dir_right) begin
                                if (hit_right) begin
                                    grid_y    <= grid_y + 10'(STEP_Y);
                                    dir_right <= 1'b0;
                                end else begin
                                    grid_x <= grid_x + 10'(STEP_X);
                                end
                            end else begin
                                if (hit_left) begin
                                    grid_y    <= grid_y + 10'(STEP_Y);
                                    dir_right <= 1'b1;
                                end else begin
                                    grid_x <= grid_x - 10'(STEP_X);
                                end
                            end
                        end else begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_invader_grid.sv
// Randomized bench for invader_grid against a per-frame behavioural model of the formation.
module tb_invader_grid;

    localparam int COLS = 6;
    localparam int ROWS = 4;
    localparam int NC   = COLS * ROWS;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            frame = 1'b0;
    logic            laser_active = 1'b0;
    logic [9:0]      laser_x = '0;
    logic [9:0]      laser_y = '0;
    logic [COLS-1:0] invader_collision;
    logic            score_pulse;
    logic [NC-1:0]   alive;
    logic [9:0]      grid_x;
    logic [9:0]      grid_y;
    logic            done;

    invader_grid dut (
        .clk(clk), .rst(rst), .frame(frame), .laser_active(laser_active),
        .laser_x(laser_x), .laser_y(laser_y), .invader_collision(invader_collision),
        .score_pulse(score_pulse), .alive(alive), .grid_x(grid_x), .grid_y(grid_y),
        .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Formation model: one call per frame, plain arithmetic on the game rules.
    logic [NC-1:0] m_alive;
    int m_gx, m_gy, m_cnt;
    bit m_right, m_done;

    task automatic model_reset();
        m_alive = '1; m_gx = 64; m_gy = 48; m_cnt = 0; m_right = 1; m_done = 0;
    endtask

    task automatic model_frame(input bit act, input int lx, input int ly, output int hit_k);
        int lc, rc, lowr, cx, cy, r, c;
        hit_k = -1;
        if (m_done) return;
        if (act) begin
            for (int k = 0; k < NC; k++) begin
                r  = ROWS - 1 - k / COLS;
                c  = k % COLS;
                cx = m_gx + c * 48;
                cy = m_gy + r * 48;
                if (m_alive[r*COLS+c] && lx < cx + 32 && lx + 4 > cx && ly < cy + 32 && ly + 16 > cy) begin
                    hit_k = k;
                    m_alive[r*COLS+c] = 1'b0;
                    break;
                end
            end
        end
        if (m_alive != '0) begin
            m_cnt++;
            if (m_cnt == 8) begin
                m_cnt = 0;
                lc = COLS; rc = -1;
                for (int i = 0; i < NC; i++) begin
                    if (m_alive[i]) begin
                        if (i % COLS < lc) lc = i % COLS;
                        if (i % COLS > rc) rc = i % COLS;
                    end
                end
                if (m_right) begin
                    if (m_gx + rc * 48 + 32 + 4 > 640) begin m_gy += 16; m_right = 0; end
                    else m_gx += 4;
                end else begin
                    if (m_gx + lc * 48 < 4) begin m_gy += 16; m_right = 1; end
                    else m_gx -= 4;
                end
            end
        end
        lowr = -1;
        for (int i = 0; i < NC; i++) if (m_alive[i] && i / COLS > lowr) lowr = i / COLS;
        m_done = (m_alive == '0) || (lowr >= 0 && m_gy + lowr * 48 + 32 >= 400);
    endtask

    int last_npulse;

    task automatic run_frame(input bit act, input int lx, input int ly, input int win);
        int exp_k, pulse_i, n_pulse, n_score;
        logic [COLS-1:0] pulse_v;
        logic score_at, done_at, done_after;
        pulse_i = -1; n_pulse = 0; n_score = 0; pulse_v = '0;
        score_at = 0; done_at = 0; done_after = 0;
        model_frame(act, lx, ly, exp_k);
        @(posedge clk); #1;
        laser_active = act;
        laser_x = lx[9:0];
        laser_y = ly[9:0];
        frame = 1'b1;
        for (int i = 1; i <= win; i++) begin
            @(posedge clk); #1;
            frame = 1'b0;
            if (invader_collision != '0) begin
                n_pulse++;
                if (pulse_i < 0) begin
                    pulse_i = i; pulse_v = invader_collision; score_at = score_pulse; done_at = done;
                end
            end
            if (score_pulse) n_score++;
            if (pulse_i >= 0 && i == pulse_i + 1) done_after = done;
        end
        laser_active = 1'b0;
        last_npulse = n_pulse;
        if (exp_k >= 0) begin
            chk_eq("pulse_cycle", pulse_i, 3 + exp_k);
            chk_eq("pulse_col", pulse_v, 1 << (exp_k % COLS));
            chk_eq("pulse_count", n_pulse, 1);
            chk_eq("score_count", n_score, 1);
            chk_eq("score_sync", score_at, 1);
            if (m_alive == '0) begin
                chk_eq("done_at_kill", done_at, 0);
                chk_eq("done_after_kill", done_after, 1);
            end
        end else begin
            chk_eq("no_pulse", n_pulse, 0);
            chk_eq("no_score", n_score, 0);
        end
        chk_eq("alive", alive, m_alive);
        chk_eq("grid_x", grid_x, m_gx);
        chk_eq("grid_y", grid_y, m_gy);
        chk_eq("done", done, m_done);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_state(input string tag);
        chk_eq({tag, "_alive"}, alive, 24'hFFFFFF);
        chk_eq({tag, "_gx"}, grid_x, 64);
        chk_eq({tag, "_gy"}, grid_y, 48);
        chk_eq({tag, "_coll"}, invader_collision, 0);
        chk_eq({tag, "_score"}, score_pulse, 0);
        chk_eq({tag, "_done"}, done, 0);
    endtask

    initial begin
        int t, idx, lx, ly, cx, cy, n_after;
        bit seen_drop, seen_back;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_state("rst_held");
        rst = 1'b0;
        @(posedge clk); #1 check_reset_state("rst_rel");

        // Eight idle frames: march step on the eighth.
        for (int f = 1; f <= 8; f++) begin
            run_frame(0, 0, 0, 6);
            if (f == 7) chk_eq("gx_after7", grid_x, 64);
        end
        chk_eq("gx_after8", grid_x, 68);
        chk_eq("gy_after8", grid_y, 48);

        // Laser on bottom-left invader, then again once it is gone.
        run_frame(1, 78, 200, 30);
        chk_eq("alive18_cleared", alive[18], 0);
        chk_eq("first_kill_pulses", last_npulse, 1);
        run_frame(1, 78, 200, 30);
        chk_eq("dead_cell_no_pulse", last_npulse, 0);

        // Long idle march: right-edge drop and left-edge drop.
        seen_drop = 0; seen_back = 0;
        for (int f = 0; f < 1400; f++) begin
            run_frame(0, 0, 0, 6);
            if (!seen_drop && grid_y == 10'd64) begin
                seen_drop = 1;
                chk_eq("drop_at_right_x", grid_x, 368);
            end else if (seen_drop && !seen_back && grid_x != 10'd368) begin
                seen_back = 1;
                chk_eq("first_left_step", grid_x, 364);
            end
        end
        chk_eq("right_drop_seen", seen_drop, 1);
        chk_eq("left_drop_y", grid_y, 80);

        // Reset in the middle of a scan that would hit cell 12 at F+15.
        do_reset();
        @(posedge clk); #1;
        laser_active = 1'b1; laser_x = 10'd70; laser_y = 10'd100; frame = 1'b1;
        @(posedge clk); #1 frame = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1 check_reset_state("midscan");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_after = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (invader_collision != '0 || score_pulse) n_after++;
        end
        chk_eq("midscan_no_pulse", n_after, 0);
        laser_active = 1'b0;
        model_reset();

        // Randomized play until the formation is wiped out.
        for (int f = 0; f < 400 && !m_done; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                lx = $urandom_range(0, 1023);
                ly = $urandom_range(0, 1023);
            end else begin
                t = $urandom_range(0, NC - 1);
                idx = t;
                for (int j = 0; j < NC; j++) begin
                    if (m_alive[(t + j) % NC]) begin idx = (t + j) % NC; break; end
                end
                cx = m_gx + (idx % COLS) * 48;
                cy = m_gy + (idx / COLS) * 48;
                lx = cx + $urandom_range(0, 42) - 6;
                ly = cy + $urandom_range(0, 52) - 18;
                if (lx < 0) lx = 0;
                if (ly < 0) ly = 0;
            end
            run_frame($urandom_range(0, 3) != 0, lx, ly, 30);
        end
        chk_eq("all_dead_done", done, 1);
        chk_eq("all_dead_alive", alive, 0);

        // Frozen while done.
        for (int f = 0; f < 3; f++) run_frame(1, $urandom_range(0, 700), $urandom_range(0, 400), 30);

        do_reset();
        check_reset_state("final_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/invader_grid.md
# invader_grid

Owns the invader formation: alive bitmap, formation position and march, and detection of player-laser hits. Sits directly downstream of the player laser block. It consumes `laser_active`, `laser_x` and `laser_y`, and produces the `invader_collision` vector the laser uses to retire itself. It also produces `done`, which ends the round, and position and alive data for the renderer.

## Interface
Parameters:
- COLS, 6, formation columns; equals width of `invader_collision`
- ROWS, 4, formation rows
- INV_W, 32, scaled invader width in px
- INV_H, 32, scaled invader height in px
- GAP_X, 16, horizontal gap between cells
- GAP_Y, 16, vertical gap between cells
- START_X, 64, formation top-left x at reset
- START_Y, 48, formation top-left y at reset
- STEP_X, 4, px per horizontal march step
- STEP_Y, 16, px per drop
- RIGHT_BOUND, 640, exclusive right screen edge
- FLOOR_Y, 400, formation bottom limit
- FRAMES_PER_STEP, 8, frames between march steps
- PROJ_W, 4, laser width in px
- PROJ_H, 16, laser height in px

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- frame  in  1  one-cycle pulse at start of blanking
- laser_active  in  1  laser present
- laser_x  in  10  laser top-left x
- laser_y  in  10  laser top-left y
- invader_collision  out  COLS  one-hot column of hit invader, one-cycle pulse
- score_pulse  out  1  one-cycle pulse per kill, coincident with `invader_collision`
- alive  out  COLS*ROWS  alive bitmap, bit index = row*COLS+col, row 0 at top
- grid_x  out  10  formation top-left x
- grid_y  out  10  formation top-left y
- done  out  1  all invaders dead or formation reached FLOOR_Y; sticky until rst

## Operation
- Reset values:
  - `alive` all ones
  - `grid_x`=START_X, `grid_y`=START_Y
  - direction right, frame counter 0, state IDLE
  - `invader_collision`=0, `score_pulse`=0, `done`=0
- Cell geometry:
  - cx = grid_x + col*(INV_W+GAP_X)
  - cy = grid_y + row*(INV_H+GAP_Y)
- FSM states and transitions:
  - IDLE: waits for `frame` -> SAMPLE. `frame` is ignored in every other state.
  - SAMPLE: latches `laser_active`, `laser_x`, `laser_y`. Sampling happens one cycle after `frame`, so the laser's frame update is captured. -> SCAN at cell (ROWS-1, 0), or -> MOVE if latched `laser_active`=0.
  - SCAN: tests one cell per cycle, bottom row first, col 0..COLS-1 within each row, rows ROWS-1 down to 0. A cell hits when it is alive AND the laser rectangle overlaps the cell rectangle:
    - lx < cx+INV_W
    - lx+PROJ_W > cx
    - ly < cy+INV_H
    - ly+PROJ_H > cy
    - On the first hit: clear that `alive` bit, pulse `invader_collision[col]` and `score_pulse` next cycle, abort the scan -> MOVE.
    - Scan completes with no hit -> MOVE.
  - MOVE: increments the frame counter.
    - If counter reaches FRAMES_PER_STEP: reset counter to 0 and march one step.
    - March extent uses the leftmost and rightmost alive columns (column alive = OR over rows).
    - Moving right: if (rightmost alive cell right edge)+STEP_X > RIGHT_BOUND, then grid_y += STEP_Y and direction flips; else grid_x += STEP_X.
    - Moving left: if (leftmost alive cell x) < STEP_X, drop and flip; else grid_x -= STEP_X.
    - -> IDLE.
- `done`:
  - Set on the cycle after `alive` becomes zero.
  - Also set when (lowest alive row bottom edge) >= FLOOR_Y after a drop.
  - While `done` is set, the FSM stays in IDLE and position and `alive` are frozen.
- Arithmetic: all geometry uses 11-bit unsigned intermediates; no wrap is permitted. `grid_x` never goes negative because of the left-edge rule.
- At most one kill per frame.

## Timing
- `frame` at cycle F:
  - SAMPLE at F+1.
  - Scan of cell k (0-based scan order) at F+2+k.
  - Hit at cell k: pulses at F+3+k, MOVE at F+3+k.
  - No hit: MOVE at F+2+COLS*ROWS.
  - IDLE on the following cycle.
- Worst-case busy time is 27 cycles at default sizes. Frame spacing is assumed to be far larger, so the collision pulse never coincides with `frame`; the laser's non-frame branch therefore sees it.
- `alive`, `grid_x` and `grid_y` change only on registered edges and stay stable through each scan.
- An asserted `rst` mid-scan forces reset values immediately; no pulse is emitted.

## Test plan
- Reset, then `frame` with `laser_active`=0 eight times -> `grid_x` 64->68 on the 8th frame, `grid_y`=48, no pulses.
- Laser at (78,200), active, then `frame` -> at F+3, `invader_collision`=6'b000001 and `score_pulse`=1 for one cycle; `alive[18]`=0.
- Laser at (78,200), but cell 18 already dead -> scan continues upward. Cell 12 spans y 144..175, so no overlap; no pulse, and the full scan takes 24 cycles.
- Force `grid_x`=368 with full columns, direction right, then a step -> `grid_y`=64, `grid_x`=368, direction left; next step gives `grid_x`=364.
- Kill all 24 invaders -> `done`=1 one cycle after the last kill. Further `frame` pulses change nothing. `rst` clears `done` and restores `alive`.
- Assert `rst` at F+10 during a scan -> all outputs at reset values immediately; no `invader_collision` pulse.
